// File: rtl/td4_pkg.sv
// +--------------------------------------------------------------+
// | td4_pkg: shared constants and loader state type for TD4       |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

package td4_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int PROG_AW    = 4;
  localparam int INSTR_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CSUM   = 2'd2,
    COMMIT = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/td4_prog_loader.sv
// +--------------------------------------------------------------+
// | td4_prog_loader: 16x8 program store with framed serial loader |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module td4_prog_loader
  import td4_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1000,
  parameter bit         BOOT_HOLD = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [PROG_AW-1:0]   fetch_addr,
  output logic [INSTR_W-1:0]   fetch_data,
  output logic                 cpu_reset_n,
  output logic                 loading,
  output logic                 load_done,
  output logic                 load_err
);

  localparam int                TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PROG_AW-1:0] IDX_LAST = PROG_AW'(PROG_DEPTH - 1);

  loader_state_t       state, next_state;
  logic [INSTR_W-1:0]  mem [PROG_DEPTH];
  logic [PROG_AW-1:0]  idx;
  logic [INSTR_W-1:0]  sum;
  logic [TW-1:0]       tmo;
  logic                ready_en;

  logic                accept;
  logic                in_frame;
  logic                is_sync;
  logic [TW-1:0]       tmo_next;
  logic                timeout;

  assign accept   = rx_valid & rx_ready;
  assign in_frame = (state == LOAD) || (state == CSUM);
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign tmo_next = tmo + 1'b1;
  // Fires on the idle cycle that would bring tmo to TIMEOUT-1; an accepted byte always wins.
  assign timeout  = in_frame && !accept && (tmo_next == TMO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept && is_sync) next_state = LOAD;
      LOAD: begin
        if (accept && (idx == IDX_LAST)) next_state = CSUM;
        else if (timeout)                next_state = IDLE;
      end
      CSUM: begin
        if (accept)       next_state = (rx_data == sum) ? COMMIT : IDLE;
        else if (timeout) next_state = IDLE;
      end
      COMMIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_ready   = ready_en && (state != COMMIT);
    loading    = in_frame;
    fetch_data = in_frame ? '0 : mem[fetch_addr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
      idx         <= '0;
      sum         <= '0;
      tmo         <= '0;
      ready_en    <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      cpu_reset_n <= !BOOT_HOLD;
    end else begin
      ready_en  <= 1'b1;
      load_done <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (accept && is_sync) begin
            idx         <= '0;
            sum         <= '0;
            tmo         <= '0;
            load_err    <= 1'b0;
            cpu_reset_n <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            mem[idx] <= rx_data;
            sum      <= sum + rx_data;
            idx      <= idx + 1'b1;
            tmo      <= '0;
          end else if (timeout) begin
            tmo      <= '0;
            load_err <= 1'b1;
          end else begin
            tmo <= tmo_next;
          end
        end
        CSUM: begin
          if (accept) begin
            tmo <= '0;
            if (rx_data != sum) load_err <= 1'b1;
          end else if (timeout) begin
            tmo      <= '0;
            load_err <= 1'b1;
          end else begin
            tmo <= tmo_next;
          end
        end
        COMMIT: cpu_reset_n <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
